// File: rtl/imem_prog_ctrl.sv
// imem_prog_ctrl: shares the instruction-memory port between core fetch (RUN)
// and a byte-stream programmer (LOAD). In LOAD the core is stalled, header byte
// N gives the word count, then 4*N little-endian bytes are packed into words
// written from word 0 upward, and a one-cycle core reset restarts fetch at PC 0.
module imem_prog_ctrl #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [31:0]       cpu_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic              pc_oob
);

    typedef enum logic [2:0] {
        RUN,
        HDR,
        BYTES,
        WRITE,
        RELEASE
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [1:0]         bidx;
    logic [31:0]        assembly;
    logic [7:0]         nwords;

    logic               rx_ready_r;
    logic               we_r;
    logic               stall_r;
    logic               rst_r;
    logic               ok_r;
    logic               err_r;

    logic               handshake;
    logic               hdr_bad;
    logic               last_word;
    logic               unused_pc_lsb;

    assign handshake = rx_valid && rx_ready_r;
    assign hdr_bad   = (rx_data == 8'd0) || (32'(rx_data) > MAX_WORDS);
    assign last_word = ((32'(ptr) + 32'd1) == 32'(nwords));

    // Next-state decode; outputs are registered from this so they are Moore.
    always_comb begin
        nxt = state;
        case (state)
            RUN:     if (prog_start) nxt = HDR;
            HDR:     if (handshake) nxt = hdr_bad ? RUN : BYTES;
            BYTES:   if (handshake && bidx == 2'd3) nxt = WRITE;
            WRITE:   nxt = last_word ? RELEASE : BYTES;
            RELEASE: nxt = RUN;
            default: nxt = RUN;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            ptr        <= '0;
            bidx       <= '0;
            assembly   <= '0;
            nwords     <= '0;
            rx_ready_r <= 1'b0;
            we_r       <= 1'b0;
            stall_r    <= 1'b0;
            rst_r      <= 1'b0;
            ok_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state      <= nxt;
            rx_ready_r <= (nxt == HDR) || (nxt == BYTES);
            we_r       <= (nxt == WRITE);
            stall_r    <= (nxt != RUN);
            rst_r      <= (nxt == RELEASE);
            case (state)
                RUN: begin
                    if (prog_start) begin
                        ok_r  <= 1'b0;
                        err_r <= 1'b0;
                        ptr   <= '0;
                        bidx  <= '0;
                    end
                end
                HDR: begin
                    if (handshake) begin
                        if (hdr_bad) err_r  <= 1'b1;
                        else         nwords <= rx_data;
                    end
                end
                BYTES: begin
                    if (handshake) begin
                        assembly[{bidx, 3'b000} +: 8] <= rx_data;
                        bidx <= bidx + 2'd1;
                    end
                end
                WRITE: begin
                    ptr  <= ptr + ADDR_W'(1);
                    bidx <= '0;
                end
                RELEASE: ok_r <= 1'b1;
                default: ;
            endcase
        end
    end

    // Port arbitration: fetch owns the address in RUN, the write pointer otherwise.
    always_comb begin
        mem_addr = (state == RUN) ? cpu_pc[ADDR_W+1:2] : ptr;
    end

    assign unused_pc_lsb = ^cpu_pc[1:0];
    assign pc_oob        = |cpu_pc[31:ADDR_W+2];
    assign mem_wdata     = assembly;
    assign mem_we        = we_r;
    assign rx_ready      = rx_ready_r;
    assign cpu_stall     = stall_r;
    assign busy          = stall_r;
    assign cpu_rst       = rst_r;
    assign load_ok       = ok_r;
    assign load_err      = err_r;

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Randomized bench for imem_prog_ctrl: drives programmer byte streams and
// compares the observed write log, core reset pulse and status flags against
// expectations computed from the load rules.
module tb_imem_prog_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [31:0] cpu_pc = 32'h0000_0014;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        cpu_stall;
    logic        cpu_rst;
    logic        busy;
    logic        load_ok;
    logic        load_err;
    logic        pc_oob;

    imem_prog_ctrl #(.ADDR_W(5), .MAX_WORDS(32)) dut (
        .clk(clk), .reset(reset), .prog_start(prog_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_pc(cpu_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .cpu_stall(cpu_stall), .cpu_rst(cpu_rst),
        .busy(busy), .load_ok(load_ok), .load_err(load_err), .pc_oob(pc_oob)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation log, sampled on the falling edge.
    int          cyc = 0;
    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          rst_n, rst_cyc, last_we_cyc, busy_n, last_busy_cyc, ready_in_write;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            last_we_cyc = cyc;
        end
        if (cpu_rst) begin
            rst_n++;
            rst_cyc = cyc;
        end
        if (busy) begin
            busy_n++;
            last_busy_cyc = cyc;
        end
        if (mem_we && rx_ready) ready_in_write++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        rst_n = 0; rst_cyc = -1; last_we_cyc = -1;
        busy_n = 0; last_busy_cyc = -1; ready_in_write = 0;
    endtask

    task automatic pulse_start();
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
    endtask

    // gap < 0 means exactly one idle cycle before the byte; else random 0..gap.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int n;
        g = (gap < 0) ? 1 : ((gap > 0) ? int'($urandom_range(0, gap)) : 0);
        rx_valid = 1'b0;
        repeat (g) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idle_timeout", 32'(n), 32'd0);
    endtask

    logic [7:0]  fixed_bytes[$];
    logic [31:0] ref_mem[32];

    // One complete programming session plus its checks.
    task automatic run_load(input logic [7:0] hdr, input int gap, input bit poke);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        logic [7:0]  b;
        bit          ok;
        int          idx;
        clear_log();
        ok  = (hdr != 8'd0) && (hdr <= 8'd32);
        idx = 0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_in_hdr", 32'(rx_ready), 32'd1);
        send_byte(hdr, gap);
        if (ok) begin
            for (int wi = 0; wi < int'(hdr); wi++) begin
                w = '0;
                for (int k = 0; k < 4; k++) begin
                    if (fixed_bytes.size() > 0) b = fixed_bytes[idx];
                    else                        b = 8'($urandom);
                    idx++;
                    w = w | (32'(b) << (8 * k));
                    if (poke && wi == 0 && k == 2) pulse_start();
                    send_byte(b, gap);
                end
                exp_w.push_back(w);
            end
        end
        wait_idle();
        check("n_writes", 32'(wr_addr.size()), ok ? 32'(hdr) : 32'd0);
        for (int i = 0; i < wr_addr.size() && i < exp_w.size(); i++) begin
            check($sformatf("waddr[%0d]", i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("wdata[%0d]", i), wr_data[i], exp_w[i]);
            ref_mem[i] = exp_w[i];
        end
        check("cpu_rst_pulses", 32'(rst_n), ok ? 32'd1 : 32'd0);
        check("load_ok", 32'(load_ok), 32'(ok));
        check("load_err", 32'(load_err), 32'(!ok));
        check("ready_during_write", 32'(ready_in_write), 32'd0);
        if (ok) begin
            check("rst_after_last_write", 32'(rst_cyc), 32'(last_we_cyc + 1));
            check("stall_release", 32'(last_busy_cyc), 32'(rst_cyc));
        end
        if (gap == 0 && !poke)
            check("busy_cycles", 32'(busy_n), ok ? 32'(5 * int'(hdr) + 2) : 32'd1);
    endtask

    initial begin
        logic [31:0] pc;
        logic [7:0]  h;
        clear_log();
        #12;
        // Reset state while reset is held.
        check("rst_mem_addr", 32'(mem_addr), 32'd5);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_ok_err", 32'({load_ok, load_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_addr", 32'(mem_addr), 32'd5);
        check("idle_busy", 32'(busy), 32'd0);

        // Fetch address mapping and out-of-range flag.
        cpu_pc = 32'h0000_0080;
        #1;
        check("oob_flag", 32'(pc_oob), 32'd1);
        check("oob_addr_wrap", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pc = (i < 4) ? 32'($urandom_range(0, 127)) : $urandom;
            cpu_pc = pc;
            #1;
            check("pc_addr", 32'(mem_addr), (pc / 4) % 32);
            check("pc_oob", 32'(pc_oob), 32'(pc >= 32'd128));
        end
        cpu_pc = '0;
        @(negedge clk);

        // Two-word image, back-to-back bytes.
        fixed_bytes = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
        run_load(8'd2, 0, 1'b0);
        check("img_word0", ref_mem[0], 32'h0050_0113);
        check("img_word1", ref_mem[1], 32'h00C0_0193);
        fixed_bytes.delete();

        // Rejected headers.
        run_load(8'd0, 0, 1'b0);
        run_load(8'd33, 0, 1'b0);

        // Single word with rx_valid gaps before every byte.
        run_load(8'd1, -1, 1'b0);

        // Reset partway through word 1 of a 3-word load.
        clear_log();
        pulse_start();
        send_byte(8'd3, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        reset = 1'b1;
        #1;
        check("midrst_stall", 32'(cpu_stall), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("midrst_ready", 32'(rx_ready), 32'd0);
        check("midrst_writes", 32'(wr_addr.size()), 32'd1);
        check("midrst_rst_pulses", 32'(rst_n), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(8'd3, 0, 1'b0);

        // prog_start while receiving bytes must not disturb the load.
        run_load(8'd2, 0, 1'b1);

        // Largest image, then a run of random sessions.
        run_load(8'd32, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0:       h = 8'($urandom_range(33, 255));
                1:       h = 8'd0;
                default: h = 8'($urandom_range(1, 32));
            endcase
            run_load(h, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
